// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: default word width, byte-lane count and
// the memory read/write encoding used by the DM stage.
package mips_pkg;

  localparam int unsigned DM_DATA_W = 16;
  localparam int unsigned DM_LANES  = DM_DATA_W / 8;

  typedef enum logic {
    MEM_RD = 1'b0,
    MEM_WR = 1'b1
  } mem_rw_e;

endpackage

// File: rtl/dm_ram.sv
// Single-port synchronous RAM, read-first, with per-byte-lane write enables.
// ena gates both the output register and the write.
module dm_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ena,
  input  logic [DATA_W/8-1:0]   we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int unsigned NLANES = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Output register: read-first, cleared by reset, held while ena is low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_q <= '0;
    end else if (ena) begin
      rdata_q <= mem[addr];
    end
  end

  // Array is deliberately not reset so it maps onto a RAM macro.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NLANES; i++) begin
      if (ena && we[i]) begin
        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dm_stage_param.sv
// MIPS DM pipeline stage: range check, sync RAM access and EX-result bypass.
// Define DM_BYTE_WRITE_EN to add the be_ex port and byte-lane stores.
module dm_stage_param
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = DM_DATA_W,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_ex,
  input  logic [DATA_W-1:0]   ans_ex,
  input  logic [DATA_W-1:0]   dm_data,
  input  logic                mem_en_ex,
  input  logic                mem_rw_ex,
  input  logic                mem_sel_ex,
`ifdef DM_BYTE_WRITE_EN
  input  logic [DATA_W/8-1:0] be_ex,
`endif
  input  logic                stall_dm,
  output logic [DATA_W-1:0]   ans_dm,
  output logic                valid_dm,
  output logic                addr_err_dm
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned NLANES = DATA_W / 8;

  logic                acc;
  logic                oor;
  logic                is_store;
  logic                is_load_sel;
  logic [NLANES-1:0]   lane_en;
  logic [NLANES-1:0]   ram_we;
  logic [DATA_W-1:0]   ram_q;

  logic [DATA_W-1:0]   ex_q,    ex_d;
  logic                sel_q,   sel_d;
  logic                valid_q, valid_d;
  logic                err_q,   err_d;

  // Full-width compare so high address bits never alias into the RAM.
  assign oor         = 64'(ans_ex) >= 64'(DEPTH);
  assign acc         = valid_ex & mem_en_ex & ~stall_dm & reset;
  assign is_store    = mem_rw_ex == MEM_WR;
  assign is_load_sel = mem_sel_ex & mem_en_ex & (mem_rw_ex == MEM_RD);

`ifdef DM_BYTE_WRITE_EN
  assign lane_en = be_ex;
`else
  assign lane_en = {NLANES{1'b1}};
`endif

  assign ram_we = {NLANES{acc & is_store & ~oor}} & lane_en;

  dm_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .ena   (acc),
    .we    (ram_we),
    .addr  (ans_ex[ADDR_W-1:0]),
    .wdata (dm_data),
    .rdata (ram_q)
  );

  always_comb begin
    ex_d    = ans_ex;
    sel_d   = is_load_sel;
    valid_d = valid_ex;
    err_d   = acc & oor;
  end

  // Pipeline registers; reset wins over stall.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_q    <= '0;
      sel_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (!stall_dm) begin
      ex_q    <= ex_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign ans_dm      = sel_q ? (err_q ? '0 : ram_q) : ex_q;
  assign valid_dm    = valid_q;
  assign addr_err_dm = err_q;

endmodule

// File: tb/tb_dm_stage_param.sv
// Scoreboard bench for dm_stage_param: stimulus pushes expected results,
// a negedge monitor pops on every advancing edge and checks holds on stalls.
module tb_dm_stage_param;

  localparam int unsigned DW  = 16;
  localparam int unsigned DEP = 1024;

  typedef struct {
    logic          v;
    logic          err;
    logic          chk;
    logic [DW-1:0] ans;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          valid_ex;
  logic [DW-1:0] ans_ex;
  logic [DW-1:0] dm_data;
  logic          mem_en_ex;
  logic          mem_rw_ex;
  logic          mem_sel_ex;
  logic [1:0]    be_ex;
  logic          stall_dm;
  logic [DW-1:0] ans_dm;
  logic          valid_dm;
  logic          addr_err_dm;

  exp_t          sbq[$];
  logic [DW-1:0] mm [DEP];
  int            n_checks = 0;
  int            n_errs   = 0;
  logic          adv_s    = 1'b0;
  logic          have_last = 1'b0;
  exp_t          last_e;

  dm_stage_param #(.DATA_W(DW), .DEPTH(DEP)) dut (
    .clk         (clk),
    .reset       (reset),
    .valid_ex    (valid_ex),
    .ans_ex      (ans_ex),
    .dm_data     (dm_data),
    .mem_en_ex   (mem_en_ex),
    .mem_rw_ex   (mem_rw_ex),
    .mem_sel_ex  (mem_sel_ex),
`ifdef DM_BYTE_WRITE_EN
    .be_ex       (be_ex),
`endif
    .stall_dm    (stall_dm),
    .ans_dm      (ans_dm),
    .valid_dm    (valid_dm),
    .addr_err_dm (addr_err_dm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a load returns the word memory holds, an out-of-range access
  // returns 0 with an error flag, anything else forwards the ALU result.
  task automatic drive(input logic rst, input logic v, input logic [DW-1:0] a,
                       input logic [DW-1:0] d, input logic en, input logic rw,
                       input logic sel, input logic st, input logic [1:0] b);
    exp_t e;
    logic [1:0] lanes;
    logic acc, oor;
    reset = rst; valid_ex = v; ans_ex = a; dm_data = d;
    mem_en_ex = en; mem_rw_ex = rw; mem_sel_ex = sel; stall_dm = st; be_ex = b;
`ifdef DM_BYTE_WRITE_EN
    lanes = b;
`else
    lanes = 2'b11;
`endif
    if (!rst) begin
      e = '{v: 1'b0, err: 1'b0, chk: 1'b1, ans: '0};
      sbq.push_back(e);
    end else if (!st) begin
      acc = v && en;
      oor = int'(a) >= int'(DEP);
      e.v   = v;
      e.err = acc && oor;
      e.chk = v;
      if (sel && en && !rw) e.ans = oor ? '0 : mm[a[9:0]];
      else                  e.ans = a;
      if (acc && rw && !oor) begin
        if (lanes[0]) mm[a[9:0]][7:0]  = d[7:0];
        if (lanes[1]) mm[a[9:0]][15:8] = d[15:8];
      end
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [DW-1:0] a, input logic [DW-1:0] d, input logic [1:0] b);
    drive(1'b1, 1'b1, a, d, 1'b1, 1'b1, 1'b0, 1'b0, b);
  endtask

  task automatic load(input logic [DW-1:0] a);
    drive(1'b1, 1'b1, a, 16'($urandom), 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
  endtask

  always @(posedge clk) adv_s = !stall_dm || !reset;

  // Monitor: new result after an advancing edge, held result otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (adv_s) begin
      if (sbq.size() == 0) begin
        chk("sb_underflow", 32'(sbq.size()), 32'd1);
      end else begin
        e = sbq.pop_front();
        chk("valid_dm", 32'(valid_dm), 32'(e.v));
        chk("addr_err_dm", 32'(addr_err_dm), 32'(e.err));
        if (e.chk) chk("ans_dm", 32'(ans_dm), 32'(e.ans));
        last_e = e;
        have_last = 1'b1;
      end
    end else if (have_last) begin
      chk("hold_valid", 32'(valid_dm), 32'(last_e.v));
      chk("hold_err", 32'(addr_err_dm), 32'(last_e.err));
      if (last_e.chk) chk("hold_ans", 32'(ans_dm), 32'(last_e.ans));
    end
  end

  initial begin
    logic [DW-1:0] a;
    int r;
    // Power-up reset, then give every address the bench touches a known value.
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 16; i++) store(16'(i), 16'($urandom), 2'b11);
    store(16'd1023, 16'($urandom), 2'b11);

    // Reset with random traffic including stores and stalls: nothing written.
    for (int i = 0; i < 2; i++)
      drive(1'b0, 1'b1, 16'($urandom_range(0, 15)), 16'($urandom), 1'b1, 1'b1,
            1'($urandom), 1'($urandom), 2'($urandom));
    for (int i = 0; i < 16; i++) load(16'(i));

    // Store then immediate load of the same word.
    store(16'd5, 16'hBEEF, 2'b11);
    load(16'd5);

    // Bypass with no memory access.
    drive(1'b1, 1'b1, 16'h1234, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 2'b11);

    // Stall holds the load result and blocks the pending store.
    load(16'd5);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 16'd5, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11);
    load(16'd5);

    // Out-of-range store and load; index 0 must not alias.
    store(16'h0400, 16'h5A5A, 2'b11);
    load(16'h0400);
    load(16'hFFFF);
    load(16'd0);
    load(16'd1023);

`ifdef DM_BYTE_WRITE_EN
    store(16'd7, 16'hAAAA, 2'b11);
    store(16'd7, 16'h1234, 2'b01);
    load(16'd7);
    store(16'd7, 16'h5555, 2'b00);
    load(16'd7);
`endif

    // Reset asserted during a stall still clears the stage.
    drive(1'b0, 1'b1, 16'd3, 16'h7777, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11);
    load(16'd3);

    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 6)      a = 16'($urandom_range(0, 15));
      else if (r == 7) a = 16'd1023;
      else if (r == 8) a = 16'(1024 + $urandom_range(0, 99));
      else             a = 16'hFFFF;
      drive(1'b1, 1'($urandom_range(0, 7) != 0), a, 16'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom_range(0, 5) == 0), 2'($urandom));
    end

    // Park the stage in stall so the monitor only checks holds, then drain.
    stall_dm = 1'b1;
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
